// File: rtl/delay_element_if.sv
// delay_if: sample bus for one delay_element instance.
//   D       : input sample word, [0:WIDTH-1], bit 0 is the MSB
//   q       : delayed sample word, same bit ordering as D
//   q_valid : q holds a sample captured after reset release
// The master side drives D and observes q/q_valid.
// The slave side is the delay line itself.
interface delay_if #(
  parameter int WIDTH = 32
);
  logic [0:WIDTH-1] D;
  logic [0:WIDTH-1] q;
  logic             q_valid;

  modport master (output D, input q, input q_valid);
  modport slave  (input D, output q, output q_valid);
endinterface

// File: rtl/delay_element.sv
// delay_element: register delay line, z^-DEPTH on a WIDTH-bit word.
// This is the unit-delay building block of the IIR filter tap lines.
// Data passes bit-exact with no arithmetic, and q comes straight from a register.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; loads RESET_VAL into every stage
//   bus   : delay_if slave (D in; q and q_valid out)
// Parameters:
//   WIDTH     : word width in bits
//   DEPTH     : number of register stages, 1..64
//   RESET_VAL : value loaded into every stage on reset
module delay_element #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 1,
  parameter logic [0:WIDTH-1] RESET_VAL = '0
) (
  input  logic   clk,
  input  logic   rst_n,
  delay_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [0:WIDTH-1] stage [DEPTH];
  logic [CW-1:0]    count;
  logic             valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RESET_VAL;
      end
    end else begin
      stage[0] <= bus.D;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // Fill counter saturates at DEPTH.
  // valid is registered from the edge on which count reaches DEPTH.
  // That makes it rise together with the first real sample on q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      valid <= 1'b0;
    end else if (count != CW'(DEPTH)) begin
      count <= count + 1'b1;
      valid <= (count == CW'(DEPTH - 1));
    end
  end

  assign bus.q       = stage[DEPTH-1];
  assign bus.q_valid = valid;

endmodule

// File: tb/tb_delay_element.sv
// tb_delay_element: directed bench for delay_element.
// It exercises these configurations:
//   u1         : WIDTH=32, DEPTH=1, RESET_VAL=0
//   uc0..uc2   : three cascaded DEPTH=1 instances (tap line)
//   u4         : WIDTH=8, DEPTH=4
//   ur         : WIDTH=32, DEPTH=2, RESET_VAL=32'hFFFF0000
// Outputs are sampled on the falling edge.
module tb_delay_element;

  logic clk = 1'b0;
  logic rst_n;
  int   assertCount = 0;
  int   failCount   = 0;

  always #5 clk = ~clk;

  delay_if #(.WIDTH(32)) bus1 ();
  delay_if #(.WIDTH(32)) busc0 ();
  delay_if #(.WIDTH(32)) busc1 ();
  delay_if #(.WIDTH(32)) busc2 ();
  delay_if #(.WIDTH(8))  bus4 ();
  delay_if #(.WIDTH(32)) busr ();

  assign busc1.D = busc0.q;
  assign busc2.D = busc1.q;

  delay_element #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'h0)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  delay_element #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'h0)) uc0 (
    .clk(clk), .rst_n(rst_n), .bus(busc0));
  delay_element #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'h0)) uc1 (
    .clk(clk), .rst_n(rst_n), .bus(busc1));
  delay_element #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'h0)) uc2 (
    .clk(clk), .rst_n(rst_n), .bus(busc2));
  delay_element #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h0)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4));
  delay_element #(.WIDTH(32), .DEPTH(2), .RESET_VAL(32'hFFFF0000)) ur (
    .clk(clk), .rst_n(rst_n), .bus(busr));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Checks that every instance shows its reset value.
  task automatic checkReset(input string phase);
    checkOutput({phase, "_q1"},  bus1.q, 32'h0);
    checkOutput({phase, "_v1"},  {31'b0, bus1.q_valid}, 32'h0);
    checkOutput({phase, "_tap2"}, busc2.q, 32'h0);
    checkOutput({phase, "_q4"},  {24'b0, bus4.q}, 32'h0);
    checkOutput({phase, "_v4"},  {31'b0, bus4.q_valid}, 32'h0);
    checkOutput({phase, "_qr"},  busr.q, 32'hFFFF0000);
    checkOutput({phase, "_vr"},  {31'b0, busr.q_valid}, 32'h0);
  endtask

  // Releases reset at the current falling edge, then runs nEdges capturing edges.
  // Expected values are the hand-derived delay of each line.
  task automatic applyStimulus(input int nEdges, input logic [7:0] base);
    logic [31:0] hr [0:63];
    logic [7:0]  e4;
    for (int n = 1; n <= nEdges; n++) begin
      bus1.D  = 32'(n);
      busc0.D = (n == 1) ? 32'd2240 : 32'd0;
      bus4.D  = base + 8'(n) - 8'd1;
      busr.D  = (n == 1) ? 32'h80000001 : 32'(n) * 32'h01010101;
      hr[n]   = busr.D;
      if (n == 1) rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("q1_%0d", n), bus1.q, 32'(n));
      checkOutput($sformatf("v1_%0d", n), {31'b0, bus1.q_valid}, 32'h1);
      checkOutput($sformatf("tap0_%0d", n), busc0.q, (n == 1) ? 32'd2240 : 32'd0);
      checkOutput($sformatf("tap1_%0d", n), busc1.q, (n == 2) ? 32'd2240 : 32'd0);
      checkOutput($sformatf("tap2_%0d", n), busc2.q, (n == 3) ? 32'd2240 : 32'd0);
      e4 = (n >= 4) ? (base + 8'(n) - 8'd4) : 8'h00;
      checkOutput($sformatf("q4_%0d", n), {24'b0, bus4.q}, {24'b0, e4});
      checkOutput($sformatf("v4_%0d", n), {31'b0, bus4.q_valid}, (n >= 4) ? 32'h1 : 32'h0);
      checkOutput($sformatf("qr_%0d", n), busr.q, (n >= 2) ? hr[n-1] : 32'hFFFF0000);
      checkOutput($sformatf("vr_%0d", n), {31'b0, busr.q_valid}, (n >= 2) ? 32'h1 : 32'h0);
      if (n == 2) checkOutput("qr_bit0_msb", {31'b0, busr.q[0]}, 32'h1);
    end
  endtask

  initial begin
    $display("[TB] start");
    rst_n   = 1'b0;
    bus1.D  = 32'hDEADBEEF;
    busc0.D = 32'hDEADBEEF;
    bus4.D  = 8'hDE;
    busr.D  = 32'hDEADBEEF;

    // Reset held with clocks running.
    repeat (3) begin
      @(negedge clk);
      checkReset("rst");
    end

    applyStimulus(16, 8'h10);

    // Pull reset low between edges while data is flowing.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 checkReset("async");
    repeat (2) begin
      @(negedge clk);
      checkReset("hold");
    end

    // The refill after release behaves as it does from power-up.
    applyStimulus(8, 8'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
